// File: rtl/lpm_table_reg_ctrl.sv
// Register-side master for the LPM route table access port.
// Host shadow registers feed table writes and capture table reads.
module lpm_table_reg_ctrl #(
    parameter int NUM_QUEUES     = 5,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = 5,
    parameter int ACK_TIMEOUT    = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_req,
    input  logic                      reg_rd_wr_L,
    input  logic [2:0]                reg_addr,
    input  logic [31:0]               reg_wr_data,
    output logic                      reg_ack,
    output logic [31:0]               reg_rd_data,
    output logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
    output logic                      lpm_rd_req,
    input  logic [31:0]               lpm_rd_ip,
    input  logic [31:0]               lpm_rd_mask,
    input  logic [31:0]               lpm_rd_next_hop_ip,
    input  logic [NUM_QUEUES-1:0]     lpm_rd_oq,
    input  logic                      lpm_rd_ack,
    output logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
    output logic                      lpm_wr_req,
    output logic [31:0]               lpm_wr_ip,
    output logic [31:0]               lpm_wr_mask,
    output logic [31:0]               lpm_wr_next_hop_ip,
    output logic [NUM_QUEUES-1:0]     lpm_wr_oq,
    input  logic                      lpm_wr_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP    = 2'd1,
        RD_WAIT = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    state_t                    r_state;
    logic [31:0]               r_ip;
    logic [31:0]               r_mask;
    logic [31:0]               r_nh;
    logic [NUM_QUEUES-1:0]     r_oq;
    logic [LUT_DEPTH_BITS-1:0] r_rd_addr;
    logic [LUT_DEPTH_BITS-1:0] r_wr_addr;
    logic                      r_timeout;
    logic                      r_addr_err;
    logic [15:0]               r_cnt;
    logic                      r_ack;
    logic [31:0]               r_rd_data;
    logic                      r_rd_req;
    logic                      r_wr_req;

    logic [31:0]               w_rd_mux;
    logic                      w_busy;
    logic                      w_addr_bad;
    logic                      w_cnt_hit;
    logic [LUT_DEPTH_BITS-1:0] w_new_addr;

    assign w_busy     = (r_state != IDLE);
    assign w_addr_bad = (reg_wr_data >= 32'(LUT_DEPTH));
    assign w_new_addr = reg_wr_data[LUT_DEPTH_BITS-1:0];
    // Counter value reached on this cycle's increment equals the limit
    assign w_cnt_hit  = (r_cnt == 16'(ACK_TIMEOUT - 1));

    // Register read multiplexer for host read accesses
    always_comb begin
        w_rd_mux = 32'd0;
        case (reg_addr)
            3'd0: w_rd_mux = r_ip;
            3'd1: w_rd_mux = r_mask;
            3'd2: w_rd_mux = r_nh;
            3'd3: w_rd_mux = 32'(r_oq);
            3'd4: w_rd_mux = 32'(r_rd_addr);
            3'd5: w_rd_mux = 32'(r_wr_addr);
            3'd6: w_rd_mux = {29'd0, r_addr_err, r_timeout, w_busy};
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Control FSM with shadows, sticky status and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ip       <= '0;
            r_mask     <= '0;
            r_nh       <= '0;
            r_oq       <= '0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_timeout  <= 1'b0;
            r_addr_err <= 1'b0;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
        end else begin
            r_ack     <= 1'b0;
            r_rd_data <= '0;
            case (r_state)
                IDLE: begin
                    if (reg_req) begin
                        if (reg_rd_wr_L) begin
                            r_rd_data <= w_rd_mux;
                            r_ack     <= 1'b1;
                            r_state   <= RESP;
                            if (reg_addr == 3'd6) begin
                                r_timeout  <= 1'b0;
                                r_addr_err <= 1'b0;
                            end
                        end else if ((reg_addr == 3'd4 || reg_addr == 3'd5) && !w_addr_bad) begin
                            r_cnt <= '0;
                            if (reg_addr == 3'd4) begin
                                r_rd_addr <= w_new_addr;
                                r_rd_req  <= 1'b1;
                                r_state   <= RD_WAIT;
                            end else begin
                                r_wr_addr <= w_new_addr;
                                r_wr_req  <= 1'b1;
                                r_state   <= WR_WAIT;
                            end
                        end else begin
                            r_ack   <= 1'b1;
                            r_state <= RESP;
                            case (reg_addr)
                                3'd0: r_ip   <= reg_wr_data;
                                3'd1: r_mask <= reg_wr_data;
                                3'd2: r_nh   <= reg_wr_data;
                                3'd3: r_oq   <= reg_wr_data[NUM_QUEUES-1:0];
                                3'd4, 3'd5: r_addr_err <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                RD_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (lpm_rd_ack) begin
                        r_ip     <= lpm_rd_ip;
                        r_mask   <= lpm_rd_mask;
                        r_nh     <= lpm_rd_next_hop_ip;
                        r_oq     <= lpm_rd_oq;
                        r_rd_req <= 1'b0;
                        r_ack    <= 1'b1;
                        r_state  <= RESP;
                    end else if (w_cnt_hit) begin
                        r_rd_req  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_ack     <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                WR_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (lpm_wr_ack) begin
                        r_wr_req <= 1'b0;
                        r_ack    <= 1'b1;
                        r_state  <= RESP;
                    end else if (w_cnt_hit) begin
                        r_wr_req  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_ack     <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign reg_ack            = r_ack;
    assign reg_rd_data        = r_rd_data;
    assign lpm_rd_addr        = r_rd_addr;
    assign lpm_rd_req         = r_rd_req;
    assign lpm_wr_addr        = r_wr_addr;
    assign lpm_wr_req         = r_wr_req;
    assign lpm_wr_ip          = r_ip;
    assign lpm_wr_mask        = r_mask;
    assign lpm_wr_next_hop_ip = r_nh;
    assign lpm_wr_oq          = r_oq;

endmodule

// File: doc/lpm_table_reg_ctrl.md
Name: lpm_table_reg_ctrl

Overview:
Register-side master for the LPM route table's read/write access port. It drives `lpm_rd_*`/`lpm_wr_*` requests and consumes their acks. A simple single-outstanding register bus from the host sees shadow registers (IP, mask, next hop, output queue) plus two trigger registers. Writing a trigger register launches a table read into the shadows, or a table write from the shadows. The block sits between the router register decoder and the IP LPM lookup block.

Parameters:
- NUM_QUEUES, 5: output-queue bitmap width.
- LUT_DEPTH, 32: number of route-table entries.
- LUT_DEPTH_BITS, 5: table address width; must satisfy 2**LUT_DEPTH_BITS >= LUT_DEPTH.
- ACK_TIMEOUT, 1023: cycles to wait for an lpm ack before aborting; 1..65535.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- reg_req, in, 1: one-cycle register access strobe.
- reg_rd_wr_L, in, 1: 1 = read, 0 = write.
- reg_addr, in, 3: word offset.
- reg_wr_data, in, 32: write data.
- reg_ack, out, 1: one-cycle completion pulse.
- reg_rd_data, out, 32: read data; valid while reg_ack=1.
- lpm_rd_addr, out, LUT_DEPTH_BITS: table read address.
- lpm_rd_req, out, 1: read request level.
- lpm_rd_ip / lpm_rd_mask / lpm_rd_next_hop_ip, in, 32 each: entry data returned by a table read.
- lpm_rd_oq, in, NUM_QUEUES: output queue returned by a table read.
- lpm_rd_ack, in, 1: read-complete pulse.
- lpm_wr_addr, out, LUT_DEPTH_BITS: table write address.
- lpm_wr_req, out, 1: write request level.
- lpm_wr_ip / lpm_wr_mask / lpm_wr_next_hop_ip, out, 32 each: entry data to write.
- lpm_wr_oq, out, NUM_QUEUES: output queue to write.
- lpm_wr_ack, in, 1: write-complete pulse.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Reset clears all shadows, status bits, counter and outputs to 0, and puts the FSM in IDLE. A reset during an lpm transaction drops the req immediately, and no reg_ack is issued.
- Register map:
  - 0 IP (RW).
  - 1 MASK (RW).
  - 2 NEXT_HOP (RW).
  - 3 OQ (RW; low NUM_QUEUES bits stored, reads zero-extended).
  - 4 RD_ADDR (write triggers a table read; reads return the last address).
  - 5 WR_ADDR (write triggers a table write; reads return the last address).
  - 6 STATUS (RO): bit0 busy, bit1 timeout sticky, bit2 addr_err sticky. Reading STATUS clears bits 1-2.
  - 7 reads 0; writes are ignored.
- lpm_wr_ip/mask/next_hop_ip/oq are continuously driven from the shadows.
- States: IDLE, RESP, RD_WAIT, WR_WAIT.
- IDLE, reg_req=1:
  - Any read, or a write to offsets 0-3, 6 or 7: perform the access and go to RESP. reg_ack=1 in the next cycle (latency 1).
  - Write to 4/5 with reg_wr_data >= LUT_DEPTH: set addr_err, issue no lpm req, go to RESP.
  - Write to 4/5, otherwise: latch the address, clear the counter, go to RD_WAIT/WR_WAIT. The matching lpm_*_req goes high in the next cycle.
- RESP: assert reg_ack with reg_rd_data for exactly one cycle, then return to IDLE. reg_rd_data is 0 when reg_ack=0.
- RD_WAIT / WR_WAIT:
  - lpm_*_req is held high; the counter increments every cycle.
  - On lpm_rd_ack: capture lpm_rd_ip/mask/next_hop_ip/oq into the shadows, drop req, go to RESP.
  - On lpm_wr_ack: drop req, go to RESP. The shadows are unchanged.
  - When the counter reaches ACK_TIMEOUT without an ack: drop req, set timeout, go to RESP. Shadows are untouched.
  - If an ack and the timeout coincide, the ack wins and no timeout is flagged.
- busy=1 in every state other than IDLE.
- reg_req outside IDLE is ignored: no effect, no ack. The bus contract is that the host waits for reg_ack.
- Stray lpm_rd_ack/lpm_wr_ack while not in the matching wait state is ignored.
- A STATUS read-clear in the same cycle as a new error set: the set wins.
- lpm_rd_req and lpm_wr_req are never high together.

Test Plan:
1. Write IP=0x0A000000, MASK=0xFF000000, NEXT_HOP=0x0A000001, OQ=0x04, then WR_ADDR=3. lpm_wr_req rises 1 cycle after reg_req with lpm_wr_addr=3 and the four values above. A model acks after 16 cycles. reg_ack follows 1 cycle after lpm_wr_ack, with one reg_ack total.
2. Write RD_ADDR=3 and have the model return ip 0xC0A80000 / mask 0xFFFF0000 / nh 0 / oq 0x10. Read offsets 0-3 and get those values, with OQ read as 0x00000010.
3. Write RD_ADDR=3 with the model never acking and ACK_TIMEOUT=20. req stays high for 20 cycles, then drops. reg_ack pulses once. STATUS reads 0x2, and a second STATUS read returns 0x0. Shadows are unchanged.
4. Write WR_ADDR=32 (LUT_DEPTH=32). No lpm_wr_req, reg_ack after 1 cycle, STATUS reads 0x4.
5. Issue a reg_req while in WR_WAIT: no ack, no shadow change. Assert reset mid-WR_WAIT: lpm_wr_req goes to 0 asynchronously, all shadows read 0 afterwards.
6. Drive lpm_wr_ack on the same cycle the counter hits ACK_TIMEOUT. reg_ack is issued and STATUS bit1 stays 0.
